// File: rtl/approx_mult_if.sv
// Handshake and data bundle for approx_mult_pipe: input operands/mode with
// valid/ready, and the product/mode result with valid/ready.
interface approx_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_a;
    logic [WIDTH-1:0]       in_b;
    logic                   in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     out_prod;
    logic                   out_mode;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_prod, out_mode
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_prod, out_mode
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned multiplier with per-transaction exact/approximate mode.
// Optional output-transfer statistics counters under APPROX_MULT_STATS_EN.
module approx_mult_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_COLS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mult_if.slave      bus
`ifdef APPROX_MULT_STATS_EN
    ,
    output logic [31:0]       op_count,
    output logic [31:0]       approx_count
`endif
);

    localparam int unsigned PW = 2 * WIDTH;
    // Columns at or above APPROX_COLS are summed exactly; those below are OR-ed.
    localparam logic [PW-1:0] HI_MASK = ~((PW'(1) << APPROX_COLS) - PW'(1));

    logic                         w_advance;

    logic                         r_s1_valid;
    logic                         r_s1_mode;
    logic [WIDTH-1:0][WIDTH-1:0]  r_s1_pp;
    logic [WIDTH-1:0][WIDTH-1:0]  w_pp;

    logic                         r_s2_valid;
    logic                         r_s2_mode;
    logic [PW-1:0]                r_s2_sum;
    logic [PW-1:0]                r_s2_carry;
    logic [PW-1:0]                r_s2_low;

    logic [PW-1:0]                w_mask;
    logic [PW-1:0]                w_row;
    logic [PW-1:0]                w_maj;
    logic [PW-1:0]                w_sum;
    logic [PW-1:0]                w_carry;
    logic [PW-1:0]                w_low;

    logic                         r_out_valid;
    logic                         r_out_mode;
    logic [PW-1:0]                r_out_prod;

    // Whole pipeline freezes only when the output holds data nobody takes.
    assign w_advance     = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_out_valid;
    assign bus.out_prod  = r_out_prod;
    assign bus.out_mode  = r_out_mode;

    // S1: one partial-product row per multiplier bit
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < WIDTH; j++) begin
            w_pp[j] = bus.in_a & {WIDTH{bus.in_b[j]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_pp    <= '0;
        end else if (w_advance) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_mode <= bus.in_mode;
                r_s1_pp   <= w_pp;
            end
        end
    end

    // S2: carry-save reduction of the exact columns, OR of the approximate ones
    always_comb begin
        w_mask  = r_s1_mode ? HI_MASK : '1;
        w_row   = '0;
        w_maj   = '0;
        w_sum   = '0;
        w_carry = '0;
        w_low   = '0;
        for (int j = 0; j < WIDTH; j++) begin
            w_row   = PW'(r_s1_pp[j]) << j;
            w_low   = w_low | (w_row & ~w_mask);
            w_row   = w_row & w_mask;
            w_maj   = (w_sum & w_carry) | (w_sum & w_row) | (w_carry & w_row);
            w_sum   = w_sum ^ w_carry ^ w_row;
            w_carry = w_maj << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_carry <= '0;
            r_s2_low   <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_mode  <= r_s1_mode;
                r_s2_sum   <= w_sum;
                r_s2_carry <= w_carry;
                r_s2_low   <= w_low;
            end
        end
    end

    // S3: the exact part has zeros below APPROX_COLS, so OR-ing the low bits is safe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out_prod  <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_mode <= r_s2_mode;
                r_out_prod <= (r_s2_sum + r_s2_carry) | r_s2_low;
            end
        end
    end

`ifdef APPROX_MULT_STATS_EN
    logic        w_xfer;
    logic [31:0] r_op_count;
    logic [31:0] r_approx_count;

    assign w_xfer       = r_out_valid && bus.out_ready;
    assign op_count     = r_op_count;
    assign approx_count = r_approx_count;

    // Saturating transfer counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count     <= 32'd0;
            r_approx_count <= 32'd0;
        end else if (w_xfer) begin
            if (r_op_count != 32'hFFFF_FFFF) begin
                r_op_count <= r_op_count + 32'd1;
            end
            if (r_out_mode && (r_approx_count != 32'hFFFF_FFFF)) begin
                r_approx_count <= r_approx_count + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe (WIDTH=8, APPROX_COLS=2): vector
// table, stall/reset sequences, and randomized traffic against a reference model.
module tb_approx_mult_pipe;
    localparam int unsigned W  = 8;
    localparam int unsigned AC = 2;
    localparam int unsigned PW = 2 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    approx_mult_if #(.WIDTH(W)) bus ();

`ifdef APPROX_MULT_STATS_EN
    logic [31:0] op_count;
    logic [31:0] approx_count;
`endif

    approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(AC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef APPROX_MULT_STATS_EN
        ,
        .op_count     (op_count),
        .approx_count (approx_count)
`endif
    );

    typedef struct {
        logic [PW-1:0] prod;
        logic          mode;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          mode;
        logic [PW-1:0] exp;
    } vec_t;

    exp_t          q[$];
    vec_t          tbl[10];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            n_pop = 0;
    int            n_pop_approx = 0;
    logic          lat_chk = 1'b1;
    logic [PW-1:0] drv_exp = '0;
    logic          last_in_ready = 1'b0;
    logic          last_acc = 1'b0;

    // Reference: approximate columns OR their partial products, the rest add up.
    function automatic logic [PW-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic mode);
        int unsigned   hi;
        logic [PW-1:0] low;
        hi  = 0;
        low = '0;
        for (int i = 0; i < int'(W); i++) begin
            for (int j = 0; j < int'(W); j++) begin
                if (a[i] && b[j]) begin
                    if (mode && (i + j) < int'(AC)) low[i+j] = 1'b1;
                    else                             hi = hi + (32'd1 << (i + j));
                end
            end
        end
        return PW'(hi) | low;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        else             n_pass++;
    endtask

    // One clock cycle: sample at negedge, score outputs, log acceptances.
    task automatic step();
        @(negedge clk);
        last_in_ready = bus.in_ready;
        last_acc      = bus.in_valid && bus.in_ready;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("out_valid_without_txn", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("prod", 32'(bus.out_prod), 32'(q[0].prod));
                chk("mode", 32'(bus.out_mode), 32'(q[0].mode));
                if (bus.out_ready) begin
                    if (lat_chk) chk("latency", 32'(cyc - q[0].cyc), 32'd3);
                    n_pop++;
                    if (q[0].mode) n_pop_approx++;
                    void'(q.pop_front());
                end
            end
        end
        if (last_acc) q.push_back('{prod: drv_exp, mode: bus.in_mode, cyc: cyc});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() > 0; k++) step();
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode,
                         input logic [PW-1:0] exp);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_mode  = mode;
        bus.in_valid = 1'b1;
        drv_exp      = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        tbl[0] = '{8'd255, 8'd255, 1'b0, 16'd65025};
        tbl[1] = '{8'd255, 8'd255, 1'b1, 16'd65023};
        tbl[2] = '{8'd3,   8'd3,   1'b1, 16'd7};
        tbl[3] = '{8'd3,   8'd3,   1'b0, 16'd9};
        tbl[4] = '{8'd0,   8'd200, 1'b1, 16'd0};
        tbl[5] = '{8'd1,   8'd1,   1'b1, 16'd1};
        tbl[6] = '{8'd2,   8'd1,   1'b1, 16'd2};
        tbl[7] = '{8'hF0,  8'h0F,  1'b1, 16'd3600};
        tbl[8] = '{8'd7,   8'd7,   1'b1, 16'd47};
        tbl[9] = '{8'd255, 8'd1,   1'b1, 16'd255};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_prod",  32'(bus.out_prod),  32'd0);
        chk("reset_out_mode",  32'(bus.out_mode),  32'd0);
        chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, each alone in the pipe
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].exp);
            step();
            chk("vec_accept", 32'(last_acc), 32'd1);
            drain();
        end

        // Full throughput: one accept per cycle, no back-pressure
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            logic         m;
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom);
            drive(a, b, m, ref_mult(a, b, m));
            step();
            chk("stream_in_ready", 32'(last_in_ready), 32'd1);
        end
        drain();

        // Four back-to-back inputs, output blocked in relative cycles 4..6
        lat_chk = 1'b0;
        p0 = n_pop;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin
                logic [W-1:0] a, b;
                a = W'($urandom);
                b = W'($urandom);
                drive(a, b, k[0], ref_mult(a, b, k[0]));
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = !(k >= 4 && k <= 6);
            step();
            if (k >= 4 && k <= 6) chk("stall_in_ready", 32'(last_in_ready), 32'd0);
        end
        drain();
        chk("stall_delivered", 32'(n_pop - p0), 32'd4);
        lat_chk = 1'b1;

        // Reset while two transactions are in flight
        drive(8'd12, 8'd34, 1'b0, ref_mult(8'd12, 8'd34, 1'b0));
        step();
        drive(8'd56, 8'd78, 1'b1, ref_mult(8'd56, 8'd78, 1'b1));
        step();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midreset_out_prod",  32'(bus.out_prod),  32'd0);
        q.delete();
        n_pop        = 0;
        n_pop_approx = 0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 0) chk("post_reset_in_ready", 32'(last_in_ready), 32'd1);
        end
        chk("post_reset_no_output", 32'(n_pop), 32'd0);
        drive(8'd200, 8'd100, 1'b0, 16'd20000);
        step();
        chk("post_reset_accept", 32'(last_acc), 32'd1);
        drain();

        // Randomized traffic with random bubbles and back-pressure
        lat_chk = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] a, b;
            logic         m;
            a = W'($urandom);
            b = W'($urandom);
            m = 1'($urandom);
            drive(a, b, m, ref_mult(a, b, m));
            bus.in_valid  = ($urandom_range(0, 7) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

`ifdef APPROX_MULT_STATS_EN
        chk("op_count",     op_count,     32'(n_pop));
        chk("approx_count", approx_count, 32'(n_pop_approx));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
